vid_seq: RTL and testbench

VID_SEQ -- requirements
Module: vid_seq

---
 rtl/vid_seq.sv | 163 ++++++++++++++++
 tb/tb_vid_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vid_seq.sv
// vid_seq: expands a vector index-sequence request into beats of
// element indices, delivered through a stallable output pipeline.
module vid_seq #(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int REQ_DATA_WIDTH    = 64,
  parameter int RESP_DATA_WIDTH   = 64,
  parameter int REQ_ADDR_WIDTH    = 5,
  parameter bit ENABLE_64_BIT     = 1,
  parameter int NUM_STAGES        = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]    in_addr,
  input  logic [1:0]                   in_sew,
  input  logic [11:0]                  in_start_idx,
  input  logic [11:0]                  in_vl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [RESP_DATA_WIDTH-1:0]  out_vec,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
  output logic                         out_last,
  output logic                         busy
);

  localparam int DW      = REQ_DATA_WIDTH;
  localparam int BW      = REQ_BYTE_EN_WIDTH;
  localparam int AW      = REQ_ADDR_WIDTH;
  localparam int LOG_BPB = $clog2(DW / 8);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic          v;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] vec;
    logic [BW-1:0] be;
  } beat_t;

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] addr_q;
  logic [1:0]    sew_q;
  logic [11:0]   start_q;
  logic [11:0]   vl_q;
  logic [11:0]   k;
  logic          accept;
  logic          empty;
  logic          stall;
  logic          gen_last;
  logic          pipe_busy;
  logic [3:0]    sh;
  logic [31:0]   nbeats;
  logic [31:0]   base;
  logic [31:0]   ei;
  logic [31:0]   bb;
  logic [31:0]   ev;
  beat_t         gen;
  beat_t         cur;

  assign accept   = in_valid && in_ready;
  assign empty    = (in_vl == 12'd0) ||
                    (in_sew == 2'd3 && !ENABLE_64_BIT);
  assign stall    = cur.v && !out_ready;
  assign sh       = 4'(LOG_BPB) - {2'b00, sew_q};
  assign nbeats   = (32'(vl_q) + (32'd1 << sh) - 32'd1) >> sh;
  assign base     = 32'(k) << sh;
  assign gen_last = (32'(k) + 32'd1) == nbeats;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept && !empty)   nxt = RUN;
      RUN:  if (!stall && gen_last) nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      sew_q   <= '0;
      start_q <= '0;
      vl_q    <= '0;
      k       <= '0;
    end else if (accept) begin
      addr_q  <= in_addr;
      sew_q   <= in_sew;
      start_q <= in_start_idx;
      vl_q    <= in_vl;
      k       <= '0;
    end else if (state == RUN && !stall) begin
      k <= k + 12'd1;
    end
  end

  // Per byte lane: element slot, byte within element, then the index value.
  always_comb begin
    gen = '0;
    ei  = '0;
    bb  = '0;
    ev  = '0;
    if (state == RUN) begin
      gen.v    = 1'b1;
      gen.last = gen_last;
      gen.addr = addr_q + AW'(k);
      for (int b = 0; b < BW; b++) begin
        ei = 32'(b) >> sew_q;
        bb = 32'(b) & ((32'd1 << sew_q) - 32'd1);
        ev = 32'(start_q) + base + ei;
        if (base + ei < 32'(vl_q)) begin
          gen.be[b]        = 1'b1;
          gen.vec[b*8 +: 8] = 8'(ev >> (bb * 32'd8));
        end
      end
    end
  end

  generate
    if (NUM_STAGES == 1) begin : g_comb
      assign cur       = gen;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      beat_t pipe [NUM_STAGES-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < NUM_STAGES - 1; s++) pipe[s] <= '0;
        end else if (!stall) begin
          pipe[0] <= gen;
          for (int s = 1; s < NUM_STAGES - 1; s++) pipe[s] <= pipe[s-1];
        end
      end

      always_comb begin
        pipe_busy = 1'b0;
        for (int s = 0; s < NUM_STAGES - 1; s++)
          pipe_busy = pipe_busy | pipe[s].v;
      end

      assign cur = pipe[NUM_STAGES-2];
    end
  endgenerate

  assign out_valid = cur.v;
  assign out_last  = cur.last;
  assign out_addr  = cur.addr;
  assign out_vec   = cur.vec;
  assign out_be    = cur.be;
  assign busy      = (state == RUN) || pipe_busy;

endmodule

// File: tb/tb_vid_seq.sv
// Directed bench for vid_seq: 64-bit beats, 3 stages, SEW=64 disabled.
module tb_vid_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [1:0]  in_sew;
  logic [11:0] in_start_idx;
  logic [11:0] in_vl;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [63:0] out_vec;
  logic [7:0]  out_be;
  logic        out_last;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vid_seq #(
    .REQ_BYTE_EN_WIDTH(8),
    .REQ_DATA_WIDTH(64),
    .RESP_DATA_WIDTH(64),
    .REQ_ADDR_WIDTH(5),
    .ENABLE_64_BIT(0),
    .NUM_STAGES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_sew(in_sew),
    .in_start_idx(in_start_idx),
    .in_vl(in_vl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_vec(out_vec),
    .out_be(out_be),
    .out_last(out_last),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [4:0] a,
                      input logic [63:0] v, input logic [7:0] be,
                      input logic last);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".addr"}, 64'(out_addr), 64'(a));
    check({tag, ".vec"}, out_vec, v);
    check({tag, ".be"}, 64'(out_be), 64'(be));
    check({tag, ".last"}, 64'(out_last), 64'(last));
  endtask

  task automatic idle_out(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".vec"}, out_vec, 64'd0);
    check({tag, ".be"}, 64'(out_be), 64'd0);
    check({tag, ".addr"}, 64'(out_addr), 64'd0);
    check({tag, ".last"}, 64'(out_last), 64'd0);
  endtask

  task automatic send(input logic [4:0] a, input logic [1:0] sew,
                      input logic [11:0] st, input logic [11:0] vl);
    in_valid     = 1'b1;
    in_addr      = a;
    in_sew       = sew;
    in_start_idx = st;
    in_vl        = vl;
    check("send.in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_addr      = '0;
    in_sew       = '0;
    in_start_idx = '0;
    in_vl        = '0;
    out_ready    = 1'b1;
    #1;
    check("rst.in_ready_low", 64'(in_ready), 64'd0);
    step();
    step();
    check("rst.in_ready_low2", 64'(in_ready), 64'd0);
    idle_out("rst");
    check("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_high", 64'(in_ready), 64'd1);

    // SEW=8, one full beat, three cycles after accept
    send(5'd5, 2'd0, 12'd0, 12'd8);
    check("b8.busy", 64'(busy), 64'd1);
    check("b8.in_ready_run", 64'(in_ready), 64'd0);
    check("b8.lat1", 64'(out_valid), 64'd0);
    step();
    check("b8.lat2", 64'(out_valid), 64'd0);
    step();
    beat("b8", 5'd5, 64'h0706050403020100, 8'hFF, 1'b1);
    step();
    idle_out("b8.after");
    check("b8.busy_end", 64'(busy), 64'd0);

    // SEW=32, address wraps, partial second beat
    send(5'd31, 2'd2, 12'd10, 12'd3);
    step();
    step();
    beat("s32.b0", 5'd31, 64'h0000000B0000000A, 8'hFF, 1'b0);
    step();
    beat("s32.b1", 5'd0, 64'h000000000000000C, 8'h0F, 1'b1);
    step();
    idle_out("s32.after");

    // SEW=8 element values wrap mod 256
    send(5'd2, 2'd0, 12'd250, 12'd8);
    step();
    step();
    beat("wrap", 5'd2, 64'h0100FFFEFDFCFBFA, 8'hFF, 1'b1);
    step();

    // SEW=16, three beats with a 4-cycle stall on the first
    send(5'd0, 2'd1, 12'd0, 12'd12);
    step();
    step();
    beat("st.b0", 5'd0, 64'h0003000200010000, 8'hFF, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      beat("st.hold", 5'd0, 64'h0003000200010000, 8'hFF, 1'b0);
      check("st.busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    step();
    beat("st.b1", 5'd1, 64'h0007000600050004, 8'hFF, 1'b0);
    step();
    beat("st.b2", 5'd2, 64'h000B000A00090008, 8'hFF, 1'b1);
    step();
    idle_out("st.after");
    check("st.busy_end", 64'(busy), 64'd0);

    // Empty requests: vl=0 and SEW=64 while disabled
    send(5'd3, 2'd0, 12'd0, 12'd0);
    check("vl0.in_ready", 64'(in_ready), 64'd1);
    check("vl0.busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("vl0.valid", 64'(out_valid), 64'd0);
      check("vl0.busy2", 64'(busy), 64'd0);
    end
    send(5'd3, 2'd3, 12'd0, 12'd5);
    check("s64.in_ready", 64'(in_ready), 64'd1);
    check("s64.busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s64.valid", 64'(out_valid), 64'd0);
      check("s64.busy2", 64'(busy), 64'd0);
    end

    // Reset during beat 2 of a 4-beat request
    send(5'd0, 2'd0, 12'd0, 12'd32);
    step();
    step();
    beat("rr.b0", 5'd0, 64'h0706050403020100, 8'hFF, 1'b0);
    step();
    beat("rr.b1", 5'd1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
    step();
    beat("rr.b2", 5'd2, 64'h1716151413121110, 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    check("rr.in_ready_rst", 64'(in_ready), 64'd0);
    step();
    idle_out("rr.reset");
    check("rr.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("rr.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr.no_residual", 64'(out_valid), 64'd0);
      check("rr.busy2", 64'(busy), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
